dot_product_feeder: RTL
=======================

DOT_PRODUCT_FEEDER -- requirements
Module: dot_product_feeder

Interface
REQ-001 Parameter LANES, default 8, meaning fp16e8 elements per beat per operand.
REQ-002 Parameter FP, default 16, meaning element width in bits (fp16e8).
REQ-003 Parameter NB_W, default 16, meaning width of the block-count field.
REQ-004 Port i_clk  input  1  sole clock; all logic rising-edge.
REQ-005 Port i_reset  input  1  asynchronous, active-high reset.
REQ-006 Port i_start  input  1  job-start pulse, sampled in IDLE only.
REQ-007 Port i_num_blocks  input  NB_W  beats in the job, latched on accepted i_start.
REQ-008 Port o_busy  output  1  high whenever state is not IDLE.
REQ-009 Port i_s_valid / o_s_ready  input / output  1 / 1  upstream beat handshake.
REQ-010 Port i_s_a, i_s_b  input  LANES*FP each  upstream operand beat.
REQ-011 Port o_a, o_b  output  LANES*FP each  operands to the dot-product stack.
REQ-012 Port o_first, o_last  output  1 each  framing to the stack (first beat, last beat).
REQ-013 Port i_sum, i_sum_valid  input  FP, 1  result and one-cycle strobe from the stack.
REQ-014 Port o_result, o_result_valid, i_result_ready  output FP, output 1, input 1  result handshake.
REQ-015 Port o_err  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 FSM states SHALL be IDLE, STREAM, DRAIN, HOLD.
REQ-017 In IDLE, i_start with i_num_blocks!=0 SHALL latch the count, clear the beat counter and go to STREAM.
REQ-018 In IDLE, i_start with i_num_blocks==0 SHALL pulse o_err for one cycle and remain in IDLE.
REQ-019 In states other than IDLE, i_start SHALL be ignored, with no o_err.
REQ-020 o_s_ready SHALL be high only in STREAM; a beat is accepted when i_s_valid and o_s_ready are both high.
REQ-021 Each accepted beat SHALL appear on o_a/o_b exactly one cycle later (registered).
REQ-022 o_first SHALL be high with the first accepted beat of the job only.
REQ-023 o_last SHALL be high with beat number i_num_blocks only; the same beat may carry o_first and o_last together (count 1).
REQ-024 In every cycle without an accepted beat in the previous cycle (bubble, DRAIN, HOLD, IDLE), o_a/o_b SHALL be all-zero and o_first/o_last low, so that the stack accumulates +0.
REQ-025 On acceptance of the final beat, the FSM SHALL go to DRAIN.
REQ-026 In DRAIN, i_sum_valid SHALL capture i_sum into o_result and go to HOLD.
REQ-027 i_sum_valid outside DRAIN SHALL be ignored.
REQ-028 In HOLD, o_result_valid SHALL be high.
REQ-029 In HOLD, o_result SHALL be stable until i_result_ready; the FSM SHALL then go to IDLE on the next edge.
REQ-030 The beat counter SHALL be NB_W bits; a count of 2^NB_W-1 SHALL complete without wrap.

Reset
REQ-031 i_reset SHALL asynchronously force IDLE, including mid-job.
REQ-032 i_reset SHALL clear all outputs to 0: o_a, o_b, o_first, o_last, o_s_ready, o_busy, o_result, o_result_valid, o_err (and o_bubble_cnt when present).
REQ-033 After reset release, no stale framing SHALL be emitted.
REQ-034 After reset release, a new i_start SHALL be accepted in the first cycle.

Configuration
REQ-035 Macro DOTP_FEEDER_PERF_EN, when defined, SHALL add output o_bubble_cnt[15:0].
REQ-036 o_bubble_cnt SHALL be cleared on job start and incremented for each STREAM cycle without an accepted beat, saturating at 16'hFFFF.
REQ-037 o_bubble_cnt SHALL be held from DRAIN until the next job start.
REQ-038 Without DOTP_FEEDER_PERF_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-039 Start, count 2; two back-to-back beats of all lanes 16'h3F80; stub returns i_sum=16'h4180 ten cycles after o_last -> o_first on beat 1, o_last on beat 2, o_result=16'h4180 with o_result_valid high until i_result_ready.
REQ-040 Start, count 3, with i_s_valid low for 2 cycles between beats 1 and 2 -> zero lanes on o_a/o_b during the gap, o_last on beat 3, o_bubble_cnt=2 (PERF build).
REQ-041 Start, count 1 -> o_first and o_last on the same cycle; next state DRAIN.
REQ-042 Start with count 0 -> single o_err pulse, o_busy stays 0; i_start in STREAM -> ignored, no o_err.
REQ-043 In HOLD, i_result_ready held low for 20 cycles with spurious i_sum_valid -> o_result unchanged; raise i_result_ready -> IDLE next cycle.
REQ-044 Assert i_reset in STREAM after 1 of 4 beats -> all outputs 0 immediately; after release, a count-2 job runs cleanly.

Source files
------------

// File: rtl/dot_product_feeder.sv
// dot_product_feeder: frames upstream operand beats into a dot-product stack and holds its result.
// Define DOTP_FEEDER_PERF_EN to add the o_bubble_cnt stall counter.
module dot_product_feeder #(
    parameter int LANES = 8,
    parameter int FP    = 16,
    parameter int NB_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [NB_W-1:0]       i_num_blocks,
    output logic                  o_busy,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [LANES*FP-1:0]   i_s_a,
    input  logic [LANES*FP-1:0]   i_s_b,
    output logic [LANES*FP-1:0]   o_a,
    output logic [LANES*FP-1:0]   o_b,
    output logic                  o_first,
    output logic                  o_last,
    input  logic [FP-1:0]         i_sum,
    input  logic                  i_sum_valid,
    output logic [FP-1:0]         o_result,
    output logic                  o_result_valid,
    input  logic                  i_result_ready,
`ifdef DOTP_FEEDER_PERF_EN
    output logic                  o_err,
    output logic [15:0]           o_bubble_cnt
`else
    output logic                  o_err
`endif
);
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, HOLD} state_t;
    state_t state_q, state_d;
    logic [NB_W-1:0] nb_q, nb_d, cnt_q, cnt_d;
    logic [LANES*FP-1:0] a_q, a_d, b_q, b_d;
    logic [FP-1:0] result_q, result_d;
    logic first_q, first_d, last_q, last_d, err_q, err_d;
    logic acc, fin, go;
    assign acc = state_q == STREAM && i_s_valid;
    assign fin = cnt_q == nb_q - NB_W'(1);
    assign go  = state_q == IDLE && i_start && i_num_blocks != '0;
    always_comb begin
        state_d  = state_q;
        nb_d     = nb_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        // idle cycles present +0 so the stack accumulator is unaffected
        a_d      = acc ? i_s_a : '0;
        b_d      = acc ? i_s_b : '0;
        first_d  = acc && cnt_q == '0;
        last_d   = acc && fin;
        err_d    = state_q == IDLE && i_start && i_num_blocks == '0;
        case (state_q)
            IDLE:    if (go) begin
                         nb_d    = i_num_blocks;
                         cnt_d   = '0;
                         state_d = STREAM;
                     end
            STREAM:  if (acc) begin
                         cnt_d   = cnt_q + NB_W'(1);
                         state_d = fin ? DRAIN : STREAM;
                     end
            DRAIN:   if (i_sum_valid) begin
                         result_d = i_sum;
                         state_d  = HOLD;
                     end
            HOLD:    state_d = i_result_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            nb_q     <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            nb_q     <= nb_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            first_q  <= first_d;
            last_q   <= last_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end
    assign o_busy         = state_q != IDLE;
    assign o_s_ready      = state_q == STREAM;
    assign o_result_valid = state_q == HOLD;
    assign o_a            = a_q;
    assign o_b            = b_q;
    assign o_first        = first_q;
    assign o_last         = last_q;
    assign o_err          = err_q;
    assign o_result       = result_q;
`ifdef DOTP_FEEDER_PERF_EN
    logic [15:0] bubble_q, bubble_d;
    always_comb begin
        bubble_d = bubble_q;
        if (go)
            bubble_d = '0;
        else if (state_q == STREAM && !i_s_valid && bubble_q != 16'hFFFF)
            bubble_d = bubble_q + 16'd1;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            bubble_q <= '0;
        else
            bubble_q <= bubble_d;
    end
    assign o_bubble_cnt = bubble_q;
`endif
endmodule
